ysyx_24100012_ifu: RTL and testbench

YSYX_24100012_IFU -- requirements
Module: ysyx_24100012_ifu

---
 rtl/ysyx_24100012_ifu.sv | 93 +++++++++
 tb/tb_ysyx_24100012_ifu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: one outstanding fetch, four-state loop
// REQ -> WAIT -> OUT -> EXEC, with a sticky misaligned-target flag.
module ysyx_24100012_ifu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  commit_valid,
    input  logic                  PCSel,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic                  misalign
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_EXEC
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] inst_nxt;
    logic                  misalign_nxt;
    logic                  active;

    // active keeps the request low until the first clock edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            inst     <= '0;
            misalign <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst     <= inst_nxt;
            misalign <= misalign_nxt;
            active   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_nxt     = inst;
        misalign_nxt = misalign;
        unique case (state)
            S_REQ: begin
                if (imem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_nxt  = imem_resp_data;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (commit_valid) begin
                    state_nxt = S_REQ;
                    if (PCSel) begin
                        pc_nxt = {target[ADDR_WIDTH-1:2], 2'b00};
                        if (target[1:0] != 2'b00) misalign_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc + ADDR_WIDTH'(4);
                    end
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    assign imem_req_valid = active && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_OUT);

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Self-checking bench for ysyx_24100012_ifu: scoreboard of expected
// fetch address/data, bench-side PC model, stall and reset scenarios.
module tb_ysyx_24100012_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        commit_valid;
    logic        PCSel;
    logic [31:0] target;
    logic        misalign;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    logic        model_mis;
    int          n_cmp;
    int          n_err;

    ysyx_24100012_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .commit_valid    (commit_valid),
        .PCSel           (PCSel),
        .target          (target),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one full fetch handshake with zero-wait memory and decode.
    task automatic drive_fetch(input logic [31:0] data,
                               output logic [31:0] ga,
                               output logic [31:0] gi,
                               output logic [31:0] gp,
                               output logic giv,
                               output bit to);
        sb.push_back('{model_pc, data});
        to = 1'b0;
        ga = '0; gi = '0; gp = '0; giv = 1'b0;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++)
            @(negedge clk);
        if (imem_req_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        ga = imem_req_addr;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        giv = inst_valid;
        gi  = inst;
        gp  = pc;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic do_commit(input logic taken, input logic [31:0] tg);
        commit_valid = 1'b1;
        PCSel        = taken;
        target       = tg;
        if (taken) begin
            model_pc = {tg[31:2], 2'b00};
            if (tg[1:0] != 2'b00) model_mis = 1'b1;
        end else begin
            model_pc = model_pc + 32'd4;
        end
        @(negedge clk);
        commit_valid = 1'b0;
        PCSel        = 1'b0;
        target       = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp += 5;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        if (pc !== RST_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
        if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", inst); end
        if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", misalign); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rel_pre_edge: got %b want 0", imem_req_valid); end
        @(negedge clk);
        n_cmp += 2;
        if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin n_err++; $display("FAIL rel_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_first_fetch;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        drive_fetch(32'h0000_0013, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 4;
        if (to) begin n_err++; $display("FAIL first_timeout: no request"); end
        else begin
            if (ga !== e.addr) begin n_err++; $display("FAIL first_addr: got %h want %h", ga, e.addr); end
            if (giv !== 1'b1) begin n_err++; $display("FAIL first_iv: got %b want 1", giv); end
            if (gi !== e.data) begin n_err++; $display("FAIL first_inst: got %h want %h", gi, e.data); end
            if (gp !== e.addr) begin n_err++; $display("FAIL first_pc: got %h want %h", gp, e.addr); end
        end
        do_commit(1'b0, 32'h0);
    endtask

    task automatic test_sequential;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        drive_fetch(32'h0010_0093, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 3;
        if (to) begin n_err++; $display("FAIL seq_timeout: no request"); end
        else begin
            if (ga !== e.addr) begin n_err++; $display("FAIL seq_addr: got %h want %h", ga, e.addr); end
            if (gi !== e.data) begin n_err++; $display("FAIL seq_inst: got %h want %h", gi, e.data); end
            if (gp !== e.addr) begin n_err++; $display("FAIL seq_pc: got %h want %h", gp, e.addr); end
        end
        do_commit(1'b1, 32'h8000_0100);
    endtask

    task automatic test_taken;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        drive_fetch(32'h0000_006f, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 3;
        if (to) begin n_err++; $display("FAIL taken_timeout: no request"); end
        else begin
            if (ga !== e.addr) begin n_err++; $display("FAIL taken_addr: got %h want %h", ga, e.addr); end
            if (gi !== e.data) begin n_err++; $display("FAIL taken_inst: got %h want %h", gi, e.data); end
            if (misalign !== model_mis) begin n_err++; $display("FAIL taken_mis: got %b want %b", misalign, model_mis); end
        end
        do_commit(1'b0, 32'h0);
    endtask

    task automatic test_stall;
        logic [31:0] d;
        d = 32'hdead_beef;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++)
            @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp += 2;
            if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, imem_req_valid); end
            if (imem_req_addr !== model_pc) begin n_err++; $display("FAIL stall_req_addr[%0d]: got %h want %h", i, imem_req_addr, model_pc); end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup_wait: got %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        commit_valid    = 1'b1;
        PCSel           = 1'b1;
        target          = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            n_cmp += 4;
            if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_iv[%0d]: got %b want 1", i, inst_valid); end
            if (inst !== d) begin n_err++; $display("FAIL stall_inst[%0d]: got %h want %h", i, inst, d); end
            if (pc !== model_pc) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, model_pc); end
            if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup_out[%0d]: got %b want 0", i, imem_req_valid); end
            @(negedge clk);
        end
        commit_valid = 1'b0;
        PCSel        = 1'b0;
        target       = '0;
        inst_ready   = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stall_exec_iv: got %b want 0", inst_valid); end
        do_commit(1'b0, 32'h0);
        n_cmp++;
        if (imem_req_addr !== model_pc) begin n_err++; $display("FAIL stall_next_addr: got %h want %h", imem_req_addr, model_pc); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        logic [31:0] tg;
        for (int k = 0; k < 6; k++) begin
            drive_fetch($urandom, ga, gi, gp, giv, to);
            e = sb.pop_front();
            n_cmp += 3;
            if (to) begin n_err++; $display("FAIL b2b_timeout[%0d]: no request", k); end
            else begin
                if (ga !== e.addr) begin n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, ga, e.addr); end
                if (gi !== e.data) begin n_err++; $display("FAIL b2b_inst[%0d]: got %h want %h", k, gi, e.data); end
                if (gp !== e.addr) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h want %h", k, gp, e.addr); end
            end
            tg = {8'h80, 22'($urandom), 2'b00};
            do_commit(1'($urandom), tg);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        do_commit_prep();
        do_commit(1'b1, 32'h8000_0102);
        n_cmp++;
        if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_set: got %b want 1", misalign); end
        drive_fetch(32'h0000_0513, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 2;
        if (to) begin n_err++; $display("FAIL mis_timeout: no request"); end
        else begin
            if (ga !== 32'h8000_0100) begin n_err++; $display("FAIL mis_addr: got %h want 80000100", ga); end
            if (misalign !== model_mis) begin n_err++; $display("FAIL mis_sticky: got %b want %b", misalign, model_mis); end
        end
        do_commit(1'b0, 32'h0);
    endtask

    // Brings the DUT from REQ through one fetch into EXEC.
    task automatic do_commit_prep;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        drive_fetch(32'h0000_0001, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || ga !== e.addr) begin n_err++; $display("FAIL prep_addr: got %h want %h", ga, e.addr); end
    endtask

    task automatic test_wrap;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        do_commit_prep();
        do_commit(1'b1, 32'hffff_fffc);
        do_commit_prep();
        do_commit(1'b0, 32'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hbad0_bad0;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        drive_fetch(32'h0000_0297, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 3;
        if (to) begin n_err++; $display("FAIL wrap_timeout: no request"); end
        else begin
            if (ga !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 00000000", ga); end
            if (gi !== e.data) begin n_err++; $display("FAIL wrap_inst: got %h want %h", gi, e.data); end
            if (misalign !== model_mis) begin n_err++; $display("FAIL wrap_mis: got %b want %b", misalign, model_mis); end
        end
        do_commit(1'b0, 32'h0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] ga, gi, gp; logic giv; bit to; exp_t e;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++)
            @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
        if (imem_req_addr !== RST_PC) begin n_err++; $display("FAIL mid_addr: got %h want %h", imem_req_addr, RST_PC); end
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_iv: got %b want 0", inst_valid); end
        if (inst !== 32'h0) begin n_err++; $display("FAIL mid_inst: got %h want 0", inst); end
        if (misalign !== 1'b0) begin n_err++; $display("FAIL mid_mis: got %b want 0", misalign); end
        @(negedge clk);
        rst_n     = 1'b1;
        model_pc  = RST_PC;
        model_mis = 1'b0;
        sb.delete();
        @(negedge clk);
        drive_fetch(32'h0000_0013, ga, gi, gp, giv, to);
        e = sb.pop_front();
        n_cmp += 2;
        if (to) begin n_err++; $display("FAIL mid_timeout: no request"); end
        else begin
            if (ga !== RST_PC) begin n_err++; $display("FAIL mid_refetch: got %h want %h", ga, RST_PC); end
            if (gi !== e.data) begin n_err++; $display("FAIL mid_inst2: got %h want %h", gi, e.data); end
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        commit_valid    = 1'b0;
        PCSel           = 1'b0;
        target          = '0;
        model_pc        = RST_PC;
        model_mis       = 1'b0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_taken();
        test_stall();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
